ysyx_24100006_lsu: RTL and testbench

//  Load/store unit between EXU and the DPI-backed data memory stage. Accepts one load/store
//  per handshake, builds byte mask and lane-shifted write data, issues a request to memory,

---
 rtl/ysyx_24100006_lsu_pkg.sv | 32 +++
 rtl/ysyx_24100006_lsu_align.sv | 51 +++++
 rtl/ysyx_24100006_lsu.sv | 116 +++++++++++
 tb/tb_ysyx_24100006_lsu.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24100006_lsu_pkg.sv
// Shared constants, state type and alignment helper for the ysyx_24100006 load/store unit.
package ysyx_24100006_pkg;

  localparam int XLEN   = 32;
  localparam int MASK_W = 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } lsu_state_t;

  // Halfwords must sit on even addresses, words on multiples of four.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (funct3)
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ysyx_24100006_lsu_align.sv
// Byte-lane steering: store mask/data shift toward memory, load extract and extend from memory.
module ysyx_24100006_lsu_align
  import ysyx_24100006_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic              is_write,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [MASK_W-1:0] wmask,
  output logic [XLEN-1:0]   wdata_lane,
  output logic [XLEN-1:0]   load_data
);

  logic [1:0]      byte_off;
  logic [3:0]      base_mask;
  logic [XLEN-1:0] rshift;

  // Halfword and word accesses drop the low address bits they cannot use.
  always_comb begin
    byte_off  = 2'b00;
    base_mask = 4'b1111;
    case (funct3)
      F3_B, F3_BU: begin
        byte_off  = addr_lo;
        base_mask = 4'b0001;
      end
      F3_H, F3_HU: begin
        byte_off  = {addr_lo[1], 1'b0};
        base_mask = 4'b0011;
      end
      default: ;
    endcase
  end

  assign wdata_lane = wdata << {byte_off, 3'b000};
  assign rshift     = rdata >> {byte_off, 3'b000};
  assign wmask      = is_write ? {4'b0000, base_mask << byte_off} : '0;

  always_comb begin
    load_data = rshift;
    case (funct3)
      F3_B:    load_data = {{24{rshift[7]}}, rshift[7:0]};
      F3_BU:   load_data = {24'h0, rshift[7:0]};
      F3_H:    load_data = {{16{rshift[15]}}, rshift[15:0]};
      F3_HU:   load_data = {16'h0, rshift[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_24100006_lsu.sv
// Blocking load/store unit, one transaction in flight: IDLE -> REQ -> WAIT -> RESP.
// Define YSYX_24100006_LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses via out_err.
module ysyx_24100006_lsu
  import ysyx_24100006_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_read,
  input  logic              in_write,
  input  logic [2:0]        in_funct3,
  input  logic [XLEN-1:0]   in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_wen,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rdata,
  output logic              out_err
);

  lsu_state_t      state, state_nxt;
  logic            read_q, write_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
  logic [XLEN-1:0] load_data;
  logic            accept, has_mem_op, trap_in;

  assign in_ready   = (state == IDLE);
  assign accept     = in_valid & in_ready;
  assign has_mem_op = in_read | in_write;

`ifdef YSYX_24100006_LSU_MISALIGN_TRAP_EN
  logic err_q;

  assign trap_in = has_mem_op & is_misaligned(in_funct3, in_addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= trap_in;
    end
  end

  assign out_err = err_q;
`else
  assign trap_in = 1'b0;
  assign out_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Requests with no memory work (or trapped ones) skip straight to the result.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = (!has_mem_op || trap_in) ? RESP : REQ;
      REQ:  if (mem_req_ready) state_nxt = WAIT;
      WAIT: if (mem_resp_valid) state_nxt = RESP;
      RESP: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else if (accept) begin
      read_q   <= in_read;
      write_q  <= in_write;
      funct3_q <= in_funct3;
      addr_q   <= in_addr;
      wdata_q  <= in_wdata;
      rdata_q  <= '0;
    end else if (state == WAIT && mem_resp_valid) begin
      rdata_q  <= read_q ? load_data : '0;
    end
  end

  assign mem_req_valid = (state == REQ);
  assign mem_wen       = write_q;
  assign mem_addr      = {addr_q[XLEN-1:2], 2'b00};
  assign out_valid     = (state == RESP);
  assign out_rdata     = rdata_q;

  ysyx_24100006_lsu_align u_align (
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .is_write   (write_q),
    .wdata      (wdata_q),
    .rdata      (mem_rdata),
    .wmask      (mem_wmask),
    .wdata_lane (mem_wdata),
    .load_data  (load_data)
  );

endmodule

// File: tb/tb_ysyx_24100006_lsu.sv
// Scoreboard bench for ysyx_24100006_lsu: directed cases plus random traffic against a byte-level model.
module tb_ysyx_24100006_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, in_read, in_write;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic        mem_req_valid, mem_req_ready, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;

  always #5 clk = ~clk;

  ysyx_24100006_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_read(in_read), .in_write(in_write),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err)
  );

  typedef struct {
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  mask;
    bit          chk_wdata;
  } req_exp_t;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
  } out_exp_t;

  typedef struct {
    logic [31:0] rdata;
    int          stall;
  } resp_t;

  req_exp_t req_q[$];
  out_exp_t out_q[$];
  resp_t    resp_q[$];

  int checks = 0;
  int errors = 0;
  bit fast = 0;
  int hold_out = 0;
  bit mem_busy = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: access size from funct3, lane offset from the size-aligned address.
  function automatic void model(input bit rd, input bit wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata,
                                output bit has_req, output req_exp_t rq, output out_exp_t oq);
    int size, off;
    bit trap;
    logic [63:0] bits, val;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off  = int'(a[1:0]) & ~(size - 1);
    trap = 0;
`ifdef YSYX_24100006_LSU_MISALIGN_TRAP_EN
    trap = (rd || wr) && ((int'(a[1:0]) % size) != 0);
`endif
    has_req      = (rd || wr) && !trap;
    rq.wen       = wr;
    rq.addr      = a & 32'hFFFF_FFFC;
    rq.wdata     = wd << (8 * off);
    rq.mask      = wr ? 8'(((1 << size) - 1) << off) : 8'h00;
    rq.chk_wdata = wr;
    bits = (64'd1 << (8 * size)) - 64'd1;
    val  = ({32'h0, rdata} >> (8 * off)) & bits;
    if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~bits;
    oq.rdata = (rd && !trap) ? val[31:0] : 32'h0;
    oq.err   = trap;
  endfunction

  task automatic issue(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rdata, input int stall);
    req_exp_t rq;
    out_exp_t oq;
    resp_t    rs;
    bit       has_req;
    int       n;
    model(rd, wr, f3, a, wd, rdata, has_req, rq, oq);
    if (has_req) begin
      req_q.push_back(rq);
      rs.rdata = rdata;
      rs.stall = stall;
      resp_q.push_back(rs);
    end
    out_q.push_back(oq);
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    in_valid = 1; in_read = rd; in_write = wr; in_funct3 = f3; in_addr = a; in_wdata = wd;
    @(negedge clk);
    in_valid = 0; in_read = 0; in_write = 0; in_funct3 = 3'($urandom);
    in_addr = $urandom; in_wdata = $urandom;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((out_q.size() != 0 || out_valid || !in_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", n < 500, 1);
  endtask

  task automatic check_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_mem_wen", mem_wen, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_err", out_err, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_wmask", mem_wmask, 0);
    check("rst_out_rdata", out_rdata, 0);
  endtask

  // Memory model: random accept delay, per-transaction response stall, stray responses when idle.
  initial begin : responder
    bit    hs;
    int    stall;
    resp_t cur;
    hs = 0; stall = 0;
    cur.rdata = 0; cur.stall = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 0;
      if (!rst_n) begin
        hs = 0;
        mem_busy = 0;
        mem_req_ready = 0;
      end else begin
        if (hs) begin
          hs = 0;
          mem_busy = 1;
          if (resp_q.size() != 0) cur = resp_q.pop_front();
          else begin cur.rdata = 0; cur.stall = 0; end
          stall = cur.stall;
        end
        if (mem_busy) begin
          if (stall == 0) begin
            mem_resp_valid = 1;
            mem_rdata = cur.rdata;
            mem_busy = 0;
          end else stall--;
        end else if ($urandom_range(0, 7) == 0) begin
          mem_resp_valid = 1;
          mem_rdata = $urandom;
        end
        mem_req_ready = fast ? 1'b1 : ($urandom_range(0, 2) != 0);
        hs = mem_req_valid && mem_req_ready;
      end
    end
  end

  initial begin : req_monitor
    bit       seen;
    req_exp_t e;
    seen = 0;
    forever begin
      @(negedge clk);
      if (!mem_req_valid) seen = 0;
      else if (!seen) begin
        seen = 1;
        if (req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mem_req actual_addr=%h required=none", mem_addr);
        end else begin
          e = req_q.pop_front();
          check("mem_wen", mem_wen, e.wen);
          check("mem_addr", mem_addr, e.addr);
          check("mem_wmask", mem_wmask, e.mask);
          if (e.chk_wdata) check("mem_wdata", mem_wdata, e.wdata);
        end
      end
    end
  end

  initial begin : out_monitor
    bit          seen;
    logic [31:0] held;
    out_exp_t    e;
    seen = 0; held = 0;
    out_ready = 0;
    forever begin
      @(negedge clk);
      if (!out_valid) seen = 0;
      else if (!seen) begin
        seen = 1;
        held = out_rdata;
        if (out_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual_rdata=%h required=none", out_rdata);
        end else begin
          e = out_q.pop_front();
          check("out_rdata", out_rdata, e.rdata);
          check("out_err", out_err, e.err);
        end
      end else check("out_rdata_stable", out_rdata, held);
      if (fast) out_ready = 1;
      else if (out_valid && hold_out > 0) begin
        out_ready = 0;
        hold_out--;
      end else out_ready = $urandom_range(0, 1);
    end
  end

  initial begin : main
    int n;
    bit seen;
    int kind;
    logic [2:0] f3;
    logic [2:0] ld_f3[5];
    ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010; ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;
    in_valid = 0; in_read = 0; in_write = 0; in_funct3 = 0; in_addr = 0; in_wdata = 0;
    #1;
    check_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    issue(0, 1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, 1);
    wait_done();
    issue(0, 1, 3'b000, 32'h8000_0003, 32'h0000_00A5, 32'h0, 0);
    wait_done();
    issue(1, 0, 3'b000, 32'h8000_0002, 32'h0, 32'h0080_0000, 2);
    issue(1, 0, 3'b100, 32'h8000_0002, 32'h0, 32'h0080_0000, 0);
    wait_done();

    fast = 1;
    @(negedge clk);
    issue(1, 0, 3'b010, 32'h8000_0010, 32'h0, 32'h1234_5678, 0);
    n = 1;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("min_latency", n, 3);
    wait_done();
    fast = 0;
    @(negedge clk);

    hold_out = 3;
    issue(1, 0, 3'b001, 32'h8000_0002, 32'h0, 32'h8001_1234, 5);
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      if (out_valid) seen = 1;
      else if (seen) break;
      check("lh_in_ready_low", in_ready, 0);
      @(negedge clk);
    end
    check("lh_completed", seen, 1);
    wait_done();

    issue(1, 0, 3'b010, 32'h8000_0008, 32'h0, 32'h5555_AAAA, 40);
    n = 0;
    while (!mem_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reached_wait", mem_busy, 1);
    @(negedge clk);
    rst_n = 0;
    #1;
    check_reset();
    req_q.delete();
    out_q.delete();
    resp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    issue(0, 1, 3'b001, 32'h8000_0006, 32'h0000_BEEF, 32'h0, 1);
    wait_done();
    issue(1, 0, 3'b101, 32'h8000_0006, 32'h0, 32'hBEEF_0000, 1);
    wait_done();

    issue(1, 0, 3'b010, 32'h8000_0002, 32'h0, 32'hCAFE_F00D, 0);
    wait_done();
    issue(0, 0, 3'b010, 32'h8000_0000, 32'h0, 32'h0, 0);
    wait_done();

    repeat (80) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        issue(0, 0, 3'($urandom), 32'h8000_0000 | ($urandom & 32'hFFFF), $urandom, $urandom, 0);
      end else if (kind <= 4) begin
        f3 = 3'($urandom_range(0, 2));
        issue(0, 1, f3, 32'h8000_0000 | ($urandom & 32'hFFFF), $urandom, $urandom,
              $urandom_range(0, 3));
      end else begin
        f3 = ld_f3[$urandom_range(0, 4)];
        issue(1, 0, f3, 32'h8000_0000 | ($urandom & 32'hFFFF), $urandom, $urandom,
              $urandom_range(0, 3));
      end
    end
    wait_done();
    check("queues_empty", req_q.size() + out_q.size() + resp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
